// File: rtl/mac_result_accumulator.sv
// Accumulates signed partial sums into one result per last-delimited group and queues results in a FIFO.
// Build option SATURATE_EN: clamp each addition instead of wrapping, and report the clamp on acc_sat_o.
module mac_result_accumulator #(
  parameter int SUM_W      = 20,
  parameter int ACC_W      = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sum_valid_i,
  input  logic [SUM_W-1:0] sum_i,
  input  logic             sum_last_i,
  input  logic             flush_i,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [CNT_W-1:0] acc_cnt_o,
  output logic             acc_sat_o,
  output logic             drop_o,
  output logic             busy_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  logic signed [ACC_W-1:0] acc_q, acc_d, base_acc, sum_ext, acc_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_d, base_cnt, cnt_nxt;
  logic                    group_start;

  logic [ACC_W-1:0] mem_acc [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_cnt [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             drop_q, drop_d;
  logic             push, pop, full, empty, push_ok;

  // A flush in the same cycle as a sum makes that sum the first of a new group.
  assign group_start = (cnt_q == '0) || flush_i;
  assign base_acc    = group_start ? '0 : acc_q;
  assign base_cnt    = group_start ? '0 : cnt_q;
  assign sum_ext     = ACC_W'($signed(sum_i));
  assign cnt_nxt     = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);

`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic             sat_q, sat_d, base_sat, step_sat, sat_nxt;
  logic [ACC_W:0]   wide_sum;
  logic             mem_sat [FIFO_DEPTH];

  assign wide_sum = {base_acc[ACC_W-1], base_acc} + {sum_ext[ACC_W-1], sum_ext};
  assign step_sat = wide_sum[ACC_W] != wide_sum[ACC_W-1];
  assign acc_nxt  = !step_sat ? wide_sum[ACC_W-1:0] : (wide_sum[ACC_W] ? ACC_MIN : ACC_MAX);
  assign base_sat = group_start ? 1'b0 : sat_q;
  assign sat_nxt  = base_sat | step_sat;
`else
  assign acc_nxt  = base_acc + sum_ext;
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
`ifdef SATURATE_EN
    sat_d = sat_q;
`endif
    if (sum_valid_i && !sum_last_i) begin
      acc_d = acc_nxt;
      cnt_d = cnt_nxt;
`ifdef SATURATE_EN
      sat_d = sat_nxt;
`endif
    end else if (sum_valid_i || flush_i) begin
      acc_d = '0;
      cnt_d = '0;
`ifdef SATURATE_EN
      sat_d = 1'b0;
`endif
    end
  end

  assign push    = sum_valid_i && sum_last_i;
  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_W'(FIFO_DEPTH));
  assign pop     = !empty && acc_ready_i;
  // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (pop && !push_ok) occ_d = occ_q - OCC_W'(1);
    if (push && !push_ok) drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_acc[wr_ptr_q] <= acc_nxt;
      mem_cnt[wr_ptr_q] <= cnt_nxt;
`ifdef SATURATE_EN
      mem_sat[wr_ptr_q] <= sat_nxt;
`endif
    end
  end

`ifdef SATURATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign acc_sat_o = !empty && mem_sat[rd_ptr_q];
`else
  assign acc_sat_o = 1'b0;
`endif

  // Storage is not reset; gating the outputs keeps the head fields at 0 while empty.
  assign acc_valid_o = !empty;
  assign acc_o       = empty ? '0 : mem_acc[rd_ptr_q];
  assign acc_cnt_o   = empty ? '0 : mem_cnt[rd_ptr_q];
  assign drop_o      = drop_q;
  assign busy_o      = (cnt_q != '0);

endmodule
